// File: rtl/core_mem_pkg.sv
// Shared encodings for the core memory-port arbiter and its starvation counter.
package core_mem_pkg;

  localparam int WORD_W = 16;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  typedef enum logic {
    DM_PRIO = 1'b0,
    IF_PRIO = 1'b1
  } prio_state_e;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Fetch starvation counter and arbitration priority state.
//   state   | meaning
//   DM_PRIO | data stage wins contention; fetch denials are counted
//   IF_PRIO | fetch wins; entered once fetch has been denied STARVE_LIMIT times in a row
module mem_arb_starve_ctr
  import core_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic if_gnt,
  output logic prio_if
);

  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;
  prio_state_e state;
  prio_state_e state_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= 4'd0;
      state <= DM_PRIO;
    end else begin
      cnt   <= cnt_nxt;
      state <= state_nxt;
    end
  end

  always_comb begin
    cnt_nxt   = 4'd0;
    state_nxt = state;
    if (if_req && !if_gnt) begin
      cnt_nxt = (cnt == 4'hF) ? cnt : cnt + 4'd1;
    end
    case (state)
      // Switch on the edge where the count reaches the limit, so fetch wins the very next cycle.
      DM_PRIO: if (cnt_nxt == 4'(STARVE_LIMIT)) state_nxt = IF_PRIO;
      IF_PRIO: if (if_gnt || !if_req) state_nxt = DM_PRIO;
      default: state_nxt = DM_PRIO;
    endcase
  end

  assign prio_if = (state == IF_PRIO);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch (read-only) and data stage,
// and tags the one-cycle-late read data to the requester that issued the read.
module mem_port_arbiter
  import core_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [WORD_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_stall,
  output logic              if_rvalid,
  output logic [WORD_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [WORD_W-1:0] dm_addr,
  input  logic [WORD_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [WORD_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
);

  logic   prio_if;
  logic   resp_valid;
  owner_e resp_owner;

  mem_arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_ctr (
    .clk    (clk),
    .reset  (reset),
    .if_req (if_req),
    .if_gnt (if_gnt),
    .prio_if(prio_if)
  );

  // Gating with reset keeps the port quiet while reset is held, not just after the edge.
  always_comb begin
    if_gnt    = reset && if_req && (prio_if || !dm_req);
    dm_gnt    = reset && dm_req && !if_gnt;
    if_stall  = reset && if_req && !if_gnt;
    mem_en    = if_gnt || dm_gnt;
    mem_we    = dm_gnt && dm_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_gnt) begin
      mem_addr = if_addr;
    end else if (dm_gnt) begin
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid <= 1'b0;
      resp_owner <= OWN_IF;
    end else begin
      resp_valid <= if_gnt || (dm_gnt && !dm_we);
      resp_owner <= dm_gnt ? OWN_DM : OWN_IF;
    end
  end

  assign if_rvalid = resp_valid && (resp_owner == OWN_IF);
  assign dm_rvalid = resp_valid && (resp_owner == OWN_DM);
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter against a denial-count reference model.
module tb_mem_port_arbiter;
  import core_mem_pkg::*;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = 16'h0;
  logic        if_gnt, if_stall, if_rvalid;
  logic [15:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [15:0] dm_addr = 16'h0;
  logic [15:0] dm_wdata = 16'h0;
  logic        dm_gnt, dm_rvalid;
  logic [15:0] dm_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = 16'h0;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_stall(if_stall),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;

  // Reference model: fetch wins if uncontended or after LIMIT consecutive denials.
  int          denials = 0;
  bit          pend_v = 1'b0;
  bit          pend_dm = 1'b0;
  logic [15:0] pend_data = 16'h0;
  bit          eg_if = 1'b0;
  bit          eg_dm = 1'b0;
  logic        dut_if_gnt = 1'b0;
  logic        dut_dm_gnt = 1'b0;
  logic [15:0] tbmem [logic [15:0]];
  logic        s_en, s_we;
  logic [15:0] s_addr, s_wdata;

  function automatic logic [15:0] mem_read(logic [15:0] a);
    if (tbmem.exists(a)) return tbmem[a];
    return a ^ 16'h5A5A;
  endfunction

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit rst_mid);
    logic [15:0] e_addr, e_wd;
    bit          e_we;
    @(negedge clk);
    eg_if  = reset && if_req && (!dm_req || denials >= LIMIT);
    eg_dm  = reset && dm_req && !eg_if;
    e_addr = eg_if ? if_addr : (eg_dm ? dm_addr : 16'h0);
    e_we   = eg_dm && dm_we;
    e_wd   = eg_dm ? dm_wdata : 16'h0;
    dut_if_gnt = if_gnt;
    dut_dm_gnt = dm_gnt;
    chk("if_gnt",    {15'b0, if_gnt},    {15'b0, eg_if});
    chk("dm_gnt",    {15'b0, dm_gnt},    {15'b0, eg_dm});
    chk("if_stall",  {15'b0, if_stall},  {15'b0, reset && if_req && !eg_if});
    chk("mem_en",    {15'b0, mem_en},    {15'b0, eg_if || eg_dm});
    chk("mem_we",    {15'b0, mem_we},    {15'b0, e_we});
    chk("mem_addr",  mem_addr,           e_addr);
    chk("mem_wdata", mem_wdata,          e_wd);
    chk("if_rvalid", {15'b0, if_rvalid}, {15'b0, pend_v && !pend_dm});
    chk("dm_rvalid", {15'b0, dm_rvalid}, {15'b0, pend_v && pend_dm});
    if (pend_v && pend_dm)  chk("dm_rdata", dm_rdata, pend_data);
    if (pend_v && !pend_dm) chk("if_rdata", if_rdata, pend_data);
    if (rst_mid) begin
      #1 reset = 1'b0;
      #1;
      chk("rst_ctl", {9'b0, if_gnt, dm_gnt, if_stall, if_rvalid, dm_rvalid, mem_en, mem_we}, 16'h0);
      chk("rst_mem_addr", mem_addr, 16'h0);
      chk("rst_mem_wdata", mem_wdata, 16'h0);
    end
    s_en = mem_en; s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata;
    @(posedge clk);
    #1;
    if (!reset) begin
      pend_v  = 1'b0;
      denials = 0;
    end else begin
      pend_v    = eg_if || (eg_dm && !dm_we);
      pend_dm   = eg_dm;
      pend_data = mem_read(e_addr);
      if (if_req && !eg_if) denials++;
      else denials = 0;
    end
    if (s_en && !s_we) mem_rdata = mem_read(s_addr);
    else mem_rdata = 16'($urandom);
    if (s_en && s_we) tbmem[s_addr] = s_wdata;
  endtask

  initial begin
    bit r;
    // Reset held
    cycle(0);
    cycle(0);
    reset = 1'b1;

    // Fetch only
    tbmem[16'h0010] = 16'hA5A5;
    if_req = 1'b1; if_addr = 16'h0010;
    cycle(0);
    chk("fetch_gnt", {15'b0, dut_if_gnt}, 16'h1);
    if_req = 1'b0;
    cycle(0);

    // Data write, then read it back
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0200; dm_wdata = 16'h1234;
    cycle(0);
    dm_req = 1'b0; dm_we = 1'b0;
    cycle(0);
    dm_req = 1'b1; dm_addr = 16'h0200;
    cycle(0);

    // Interleaved: dm read then fetch
    tbmem[16'h0300] = 16'hBEEF;
    tbmem[16'h0011] = 16'hC0DE;
    dm_addr = 16'h0300;
    cycle(0);
    dm_req = 1'b0; if_req = 1'b1; if_addr = 16'h0011;
    cycle(0);
    if_req = 1'b0;
    cycle(0);

    // Continuous contention
    if_req = 1'b1; if_addr = 16'h0020; dm_req = 1'b1; dm_we = 1'b0;
    for (int i = 0; i < 15; i++) begin
      dm_addr = 16'h0300 + 16'(i);
      cycle(0);
      chk("contend_if_gnt", {15'b0, dut_if_gnt}, (i % 5 == 4) ? 16'h1 : 16'h0);
      chk("contend_dm_gnt", {15'b0, dut_dm_gnt}, (i % 5 == 4) ? 16'h0 : 16'h1);
    end

    // Idle
    if_req = 1'b0; dm_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle(0);
      chk("idle_cnt", {12'b0, dut.u_ctr.cnt}, 16'h0);
    end

    // Reset mid-read, after three denials so the counter is nonzero
    if_req = 1'b1; dm_req = 1'b1;
    for (int i = 0; i < 3; i++) cycle(0);
    dm_addr = 16'h0300;
    cycle(1);
    if_req = 1'b0; dm_req = 1'b0;
    cycle(0);
    reset = 1'b1;
    chk("post_rst_cnt", {12'b0, dut.u_ctr.cnt}, 16'h0);
    if_req = 1'b1; dm_req = 1'b1;
    cycle(0);
    chk("post_rst_dm_wins", {15'b0, dut_dm_gnt}, 16'h1);
    cycle(0);

    // Randomized traffic honouring the hold-until-grant rule
    for (int k = 0; k < 400; k++) begin
      if (!if_req || eg_if) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = 16'h0400 + 16'($urandom_range(0, 15));
      end
      if (!dm_req || eg_dm) begin
        dm_req   = ($urandom_range(0, 3) != 0);
        dm_we    = ($urandom_range(0, 2) == 0);
        dm_addr  = 16'h0400 + 16'($urandom_range(0, 15));
        dm_wdata = 16'($urandom);
      end
      r = ($urandom_range(0, 59) == 0);
      cycle(r);
      if (r) begin
        cycle(0);
        reset = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares the core's single 16-bit word-addressed memory port between two requesters: the instruction-fetch stage (read-only) and the data-memory stage (read/write).
- Grants at most one access per cycle and drives the memory port combinationally from the winner. It returns read data one cycle later, tagged to the requester that issued the read.
- Data accesses normally win. A starvation counter forces one fetch grant after a bounded number of denials.
- Sits between the fetch/memory pipeline stages and the memory macro. It also produces the fetch stall.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive fetch denials before fetch is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low
- if_req  in  1  fetch requests a read this cycle
- if_addr  in  16  fetch word address
- if_gnt  out  1  fetch access accepted this cycle
- if_stall  out  1  if_req & ~if_gnt
- if_rvalid  out  1  if_rdata valid (read granted previous cycle)
- if_rdata  out  16  read data to fetch
- dm_req  in  1  data stage requests an access
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  16  data word address
- dm_wdata  in  16  write data
- dm_gnt  out  1  data access accepted this cycle
- dm_rvalid  out  1  dm_rdata valid
- dm_rdata  out  16  read data to data stage
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data; valid one cycle after the mem_en/~mem_we cycle

## Operation
Priority FSM, two states:
- DM_PRIO (reset state): dm_req wins; otherwise if_req wins.
- IF_PRIO: if_req wins; otherwise dm_req wins.

Starvation counter (width 4):
- Increments when if_req=1 and if_gnt=0.
- Clears when if_gnt=1, or when if_req=0.
- DM_PRIO -> IF_PRIO when the counter equals STARVE_LIMIT at a clock edge.
- IF_PRIO -> DM_PRIO after any cycle with if_gnt=1, or any cycle with if_req=0.

Memory port:
- On any grant, mem_en=1; mem_addr, mem_we and mem_wdata come from the winner.
- For a fetch grant, mem_we=0 and mem_wdata=0.
- With no grant, all mem_* outputs are 0.

Read response:
- A registered resp_valid/resp_owner pair is set on each granted read; writes do not set it.
- Next cycle, exactly one of if_rvalid/dm_rvalid is 1, according to resp_owner.
- if_rdata and dm_rdata both carry mem_rdata unconditionally; the rvalid signals qualify them.

Other rules:
- Requesters hold req, addr and data stable until their gnt is seen.
- While reset is low, gnt, mem_en and mem_we are forced to 0.

## Timing
- Grant is combinational, same cycle as req. Read latency is exactly 1 cycle, from grant to rvalid.
- Back-to-back grants are allowed every cycle, with alternating owners. rvalid ownership follows the grant sequence with 1-cycle skew.
- Simultaneous if_req and dm_req: the FSM state decides the winner; the loser's gnt=0 and if_stall=1 when fetch loses.
- Write granted while a previous read response is pending: the response is still delivered next cycle, unaffected.
- Reset asserted mid-operation:
  - All outputs go to 0 immediately: gnt, rvalid, stall, mem_*.
  - A pending read response is discarded; the FSM returns to DM_PRIO; the counter returns to 0.
- First edge after reset release: normal arbitration; no spurious rvalid.
- STARVE_LIMIT=1: fetch wins every second cycle under continuous contention.

## Structure
- Shared package core_mem_pkg holds:
  - owner encoding: OWN_IF=1'b0, OWN_DM=1'b1
  - FSM state encoding: DM_PRIO=1'b0, IF_PRIO=1'b1
  - 16-bit word width constant
- One natural sub-module, mem_arb_starve_ctr: the counter plus the DM_PRIO/IF_PRIO state, with outputs prio_if and inputs if_req and if_gnt.
- Grant mux, memory drive and response tagging stay in the top module.

## Test plan
- Fetch only: if_req=1, if_addr=0x0010, mem holds 0xA5A5 -> if_gnt=1 and mem_addr=0x0010 same cycle; if_rvalid=1 and if_rdata=0xA5A5 next cycle; dm_rvalid=0.
- Data write: dm_req=1, dm_we=1, addr 0x0200, wdata 0x1234, no fetch -> mem_en=1, mem_we=1, mem_wdata=0x1234; no rvalid next cycle.
- Contention: both requesting continuously, STARVE_LIMIT=4 -> dm_gnt for 4 cycles with if_stall=1, if_gnt in the 5th, then repeat; every read's rvalid goes to the correct owner.
- Interleaved: dm read 0x0300, then fetch 0x0011 next cycle -> dm_rvalid in cycle 2, if_rvalid in cycle 3, each with correct data.
- Reset mid-read: read granted, reset low before the next edge -> no rvalid; after release, the counter is 0 and dm_req wins the first contended cycle.
- Idle: no requests for 10 cycles -> mem_en=0, both rvalid=0, counter stays 0.
